// File: rtl/tt_uio_arb_pkg.sv
// Shared types and counter widths for the uio bus arbiter.
// Widths cover the full legal parameter ranges so every instance shares one layout.
package tt_uio_arb_pkg;

    localparam int unsigned TURN_CYCLES_MAX = 15;
    localparam int unsigned MAX_HOLD_MAX    = 255;
    localparam int unsigned TURN_W          = $clog2(TURN_CYCLES_MAX + 1);
    localparam int unsigned HOLD_W          = $clog2(MAX_HOLD_MAX + 1);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StTurn = 2'd1,
        StOwnA = 2'd2,
        StOwnB = 2'd3
    } arb_state_e;

endpackage

// File: rtl/tt_uio_arbiter_if.sv
// Requester/pad signal bundle for the uio arbiter.
// The slave modport is the arbiter's view; the master modport is the requester/pad side.
interface tt_uio_arbiter_if;

    logic       ena;
    logic       req_a;
    logic       req_b;
    logic [7:0] out_a;
    logic [7:0] out_b;
    logic [7:0] oe_a;
    logic [7:0] oe_b;
    logic       gnt_a;
    logic       gnt_b;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;
    logic [7:0] uio_in;
    logic [7:0] uio_in_sync;

    modport slave (
        input  ena, req_a, req_b, out_a, out_b, oe_a, oe_b, uio_in,
        output gnt_a, gnt_b, uio_out, uio_oe, uio_in_sync
    );

    modport master (
        output ena, req_a, req_b, out_a, out_b, oe_a, oe_b, uio_in,
        input  gnt_a, gnt_b, uio_out, uio_oe, uio_in_sync
    );

endinterface

// File: rtl/tt_sync2.sv
// Two-flop synchronizer with asynchronous active-low reset.
module tt_sync2 #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/tt_uio_arbiter.sv
// Round-robin arbiter sharing the uio pads between two requesters, with a dead-cycle
// turnaround between owners and a hold limit that only bites under contention.
module tt_uio_arbiter #(
    parameter int unsigned TURN_CYCLES = 1,
    parameter int unsigned MAX_HOLD    = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    tt_uio_arbiter_if.slave bus
);

    import tt_uio_arb_pkg::*;

    localparam logic [TURN_W-1:0] TurnLast = TURN_W'(TURN_CYCLES - 1);
    localparam logic [HOLD_W-1:0] MaxHold  = HOLD_W'(MAX_HOLD);

    arb_state_e        state_q, state_d;
    logic              last_b_q, last_b_d;
    logic              target_b_q, target_b_d;
    logic [HOLD_W-1:0] hold_q, hold_d, hold_inc;
    logic [TURN_W-1:0] turn_q, turn_d;
    logic              preempt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            last_b_q   <= 1'b1;
            target_b_q <= 1'b0;
            hold_q     <= '0;
            turn_q     <= '0;
        end else begin
            state_q    <= state_d;
            last_b_q   <= last_b_d;
            target_b_q <= target_b_d;
            hold_q     <= hold_d;
            turn_q     <= turn_d;
        end
    end

    // hold_inc is the owned-cycle count including the cycle now ending.
    assign hold_inc = (hold_q == MaxHold) ? hold_q : hold_q + 1'b1;
    assign preempt  = (hold_inc == MaxHold);

    always_comb begin
        state_d    = state_q;
        last_b_d   = last_b_q;
        target_b_d = target_b_q;
        hold_d     = '0;
        turn_d     = '0;

        unique case (state_q)
            StIdle: begin
                if (bus.req_a && (!bus.req_b || last_b_q)) state_d = StOwnA;
                else if (bus.req_b)                        state_d = StOwnB;
            end
            StTurn: begin
                if (turn_q == TurnLast) begin
                    if (target_b_q ? bus.req_b : bus.req_a) begin
                        state_d = target_b_q ? StOwnB : StOwnA;
                    end else if (target_b_q ? bus.req_a : bus.req_b) begin
                        state_d = target_b_q ? StOwnA : StOwnB;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StOwnA: begin
                if (!bus.req_a || (preempt && bus.req_b)) begin
                    state_d    = bus.req_b ? StTurn : StIdle;
                    target_b_d = 1'b1;
                end
            end
            StOwnB: begin
                if (!bus.req_b || (preempt && bus.req_a)) begin
                    state_d    = bus.req_a ? StTurn : StIdle;
                    target_b_d = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase

        if (!bus.ena) state_d = StIdle;

        if (state_d == StOwnA && state_q != StOwnA) last_b_d = 1'b0;
        if (state_d == StOwnB && state_q != StOwnB) last_b_d = 1'b1;

        // Counters run only while staying in the same state; any transition clears them.
        if ((state_q == StOwnA || state_q == StOwnB) && state_d == state_q) hold_d = hold_inc;
        if (state_q == StTurn && state_d == StTurn) turn_d = turn_q + 1'b1;
    end

    assign bus.gnt_a   = (state_q == StOwnA);
    assign bus.gnt_b   = (state_q == StOwnB);
    assign bus.uio_out = (state_q == StOwnA) ? bus.out_a :
                         (state_q == StOwnB) ? bus.out_b : 8'h00;
    assign bus.uio_oe  = (state_q == StOwnA) ? bus.oe_a :
                         (state_q == StOwnB) ? bus.oe_b : 8'h00;

    tt_sync2 #(
        .WIDTH (8)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (bus.uio_in),
        .q     (bus.uio_in_sync)
    );

endmodule

// File: tb/tb_tt_uio_arbiter.sv
// Directed bench for tt_uio_arbiter: three instances cover default, short-hold and
// long-turnaround configurations, sharing one clock and reset.
module tb_tt_uio_arbiter;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    tt_uio_arbiter_if if0 ();
    tt_uio_arbiter_if if1 ();
    tt_uio_arbiter_if if2 ();

    tt_uio_arbiter #(.TURN_CYCLES(1), .MAX_HOLD(16)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    tt_uio_arbiter #(.TURN_CYCLES(1), .MAX_HOLD(4))  dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    tt_uio_arbiter #(.TURN_CYCLES(3), .MAX_HOLD(16)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));

    // Observed bus word: {gnt_a, gnt_b, uio_oe, uio_out}
    function automatic logic [17:0] v0();
        return {if0.gnt_a, if0.gnt_b, if0.uio_oe, if0.uio_out};
    endfunction
    function automatic logic [17:0] v1();
        return {if1.gnt_a, if1.gnt_b, if1.uio_oe, if1.uio_out};
    endfunction
    function automatic logic [17:0] v2();
        return {if2.gnt_a, if2.gnt_b, if2.uio_oe, if2.uio_out};
    endfunction

    localparam logic [17:0] OFF  = 18'h0;
    localparam logic [17:0] OWNA = {1'b1, 1'b0, 8'h0F, 8'h3C};
    localparam logic [17:0] OWNB = {1'b0, 1'b1, 8'hF0, 8'hC3};

    task automatic check(input string tag, input logic [17:0] obs, input logic [17:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        if0.ena = 1'b1; if0.req_a = 1'b0; if0.req_b = 1'b0; if0.uio_in = 8'h00;
        if0.out_a = 8'h3C; if0.oe_a = 8'h0F; if0.out_b = 8'hC3; if0.oe_b = 8'hF0;
        if1.ena = 1'b1; if1.req_a = 1'b0; if1.req_b = 1'b0; if1.uio_in = 8'h00;
        if1.out_a = 8'h3C; if1.oe_a = 8'h0F; if1.out_b = 8'hC3; if1.oe_b = 8'hF0;
        if2.ena = 1'b1; if2.req_a = 1'b0; if2.req_b = 1'b0; if2.uio_in = 8'h00;
        if2.out_a = 8'h3C; if2.oe_a = 8'h0F; if2.out_b = 8'hC3; if2.oe_b = 8'hF0;

        #1 rst_n = 1'b0;
        #1;
        check("reset bus", v0(), OFF);
        check("reset sync", {10'b0, if0.uio_in_sync}, 18'h0);
        #10 rst_n = 1'b1;

        // Single requester from IDLE: grant one edge later, never combinationally.
        tick();
        if0.req_a = 1'b1;
        #1 check("no comb req->gnt", v0(), OFF);
        tick();
        check("a first grant", v0(), OWNA);

        // Uncontended owner keeps the bus well past MAX_HOLD.
        repeat (20) tick();
        check("a holds uncontended", v0(), OWNA);

        if0.uio_in = 8'hA5;
        tick();
        check("sync after 1 edge", {10'b0, if0.uio_in_sync}, 18'h0);
        tick();
        check("sync after 2 edges", {10'b0, if0.uio_in_sync}, {10'b0, 8'hA5});

        // Asynchronous reset while A owns the bus.
        rst_n = 1'b0;
        #1;
        check("async reset mid-own", v0(), OFF);
        check("async reset sync", {10'b0, if0.uio_in_sync}, 18'h0);
        #2 rst_n = 1'b1;
        tick();
        check("grant after reset", v0(), OWNA);
        if0.req_a = 1'b0;
        tick();
        check("a released", v0(), OFF);

        // Fresh reset so last-granted is B again, then simultaneous requests.
        rst_n = 1'b0;
        #1 rst_n = 1'b1;
        if0.req_a = 1'b1;
        if0.req_b = 1'b1;
        tick();
        check("tie goes to a", v0(), OWNA);
        tick();
        tick();
        check("a keeps under short contention", v0(), OWNA);
        if0.req_a = 1'b0;
        tick();
        check("turn dead cycle", v0(), OFF);
        tick();
        check("b after turn", v0(), OWNB);
        if0.req_b = 1'b0;
        tick();
        check("b released", v0(), OFF);

        // Enable drop during OWN_B.
        if0.req_b = 1'b1;
        tick();
        check("b granted alone", v0(), OWNB);
        if0.ena = 1'b0;
        tick();
        check("ena low forces idle", v0(), OFF);
        tick();
        check("no grant while ena low", v0(), OFF);
        if0.ena = 1'b1;
        tick();
        check("b regrant after ena", v0(), OWNB);
        if0.req_b = 1'b0;
        tick();

        // MAX_HOLD=4 preemption and round-robin handoff.
        if1.req_a = 1'b1;
        if1.req_b = 1'b1;
        tick();
        check("mh a owned 1", v1(), OWNA);
        tick();
        tick();
        tick();
        check("mh a owned 4", v1(), OWNA);
        tick();
        check("mh preempt turn", v1(), OFF);
        tick();
        check("mh b owned 1", v1(), OWNB);
        tick();
        tick();
        tick();
        check("mh b owned 4", v1(), OWNB);
        tick();
        check("mh second turn", v1(), OFF);
        tick();
        check("mh round-robin back to a", v1(), OWNA);
        if1.req_a = 1'b0;
        if1.req_b = 1'b0;
        tick();
        check("mh released", v1(), OFF);

        // TURN_CYCLES=3: target B withdraws during turnaround, A takes over.
        if2.req_a = 1'b1;
        tick();
        check("t3 a owns", v2(), OWNA);
        if2.req_b = 1'b1;
        tick();
        if2.req_a = 1'b0;
        tick();
        check("t3 dead 1", v2(), OFF);
        if2.req_b = 1'b0;
        if2.req_a = 1'b1;
        if2.oe_a  = 8'hFF;
        tick();
        check("t3 dead 2", v2(), OFF);
        tick();
        check("t3 dead 3", v2(), OFF);
        tick();
        check("t3 a after turn", v2(), {1'b1, 1'b0, 8'hFF, 8'h3C});
        if2.req_a = 1'b0;
        tick();
        check("t3 released", v2(), OFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
